// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    localparam logic MDU_MULT = 1'b0;
    localparam logic MDU_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        FIX,
        DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign correction applied to the unsigned magnitude result.
// Mult negates the whole product; div negates the quotient and gives the remainder the dividend's sign.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic               op_i,
    input  logic               sign_a_i,
    input  logic               sign_b_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0]   hi_c,
    output logic [WIDTH-1:0]   lo_c
);

    logic               neg_c;
    logic [2*WIDTH-1:0] prod_c;

    assign neg_c = sign_a_i ^ sign_b_i;

    always_comb begin
        prod_c = neg_c ? -acc_i : acc_i;
        hi_c   = prod_c[2*WIDTH-1:WIDTH];
        lo_c   = prod_c[WIDTH-1:0];
        if (op_i == MDU_DIV) begin
            lo_c = neg_c    ? -acc_i[WIDTH-1:0]       : acc_i[WIDTH-1:0];
            hi_c = sign_a_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// one iteration per cycle over operand magnitudes, sign fix-up at the end.
module mult_div_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clck,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    mdu_state_e       state_q, state_d;
    logic             op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy_d, done_d, div_zero_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH-1:0] fix_hi_c, fix_lo_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic             div_by_zero_c, last_iter_c;
    logic [WIDTH:0]   mul_sum_c, div_shift_c;
    logic [WIDTH-1:0] div_diff_c;
    logic             div_ge_c;

    // Magnitude of the most negative value is its own unsigned bit pattern, so no overflow.
    assign mag_a_c       = a[WIDTH-1] ? -a : a;
    assign mag_b_c       = b[WIDTH-1] ? -b : b;
    assign div_by_zero_c = (op_q == MDU_DIV) && (opnd_q == '0);
    assign last_iter_c   = (cnt_q == CNT_W'(WIDTH - 1));

    // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
    assign mul_sum_c   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift_c = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge_c    = (div_shift_c >= {1'b0, opnd_q});
    assign div_diff_c  = div_shift_c[WIDTH-1:0] - opnd_q;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_i     (op_q),
        .sign_a_i (sign_a_q),
        .sign_b_i (sign_b_q),
        .acc_i    (acc_q),
        .hi_c     (fix_hi_c),
        .lo_c     (fix_lo_c)
    );

    always_ff @(posedge clck) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = div_by_zero_c ? DONE : RUN;
            RUN:     if (last_iter_c) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and one iteration step per RUN cycle
    always_comb begin
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
                    cnt_d    = '0;
                    opnd_d   = (op == MDU_DIV) ? mag_b_c : mag_a_c;
                    acc_d    = {{WIDTH{1'b0}}, ((op == MDU_DIV) ? mag_a_c : mag_b_c)};
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q == MDU_MULT) begin
                    acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
                end else if (div_ge_c) begin
                    acc_d = {div_diff_c, acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d     = (state_q == CHECK) || (state_q == RUN) || (state_q == FIX);
        done_d     = (state_q == DONE);
        div_zero_d = (state_q == DONE) && div_by_zero_c;
        hi_d       = hi;
        lo_d       = lo;
        if (state_q == FIX) begin
            hi_d = fix_hi_c;
            lo_d = fix_lo_c;
        end
    end

    always_ff @(posedge clck) begin
        if (reset) begin
            op_q     <= MDU_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            div_zero <= div_zero_d;
            hi       <= hi_d;
            lo       <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: expected HI/LO/div_zero queued at issue, compared on done.
module tb_mult_div_sequencer;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    logic         clck = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    mult_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clck     (clck),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clck = ~clck;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic; div-by-zero leaves HI/LO as they were
    task automatic push_exp(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == MDU_MULT) begin
            p    = 64'(sx * sy);
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
        end else if (y == '0) begin
            e.hi = mdl_hi;
            e.lo = mdl_lo;
            e.dz = 1'b1;
        end else begin
            q    = sx / sy;
            r    = sx % sy;
            e.lo = W'(q);
            e.hi = W'(r);
            e.dz = 1'b0;
        end
        mdl_hi = e.hi;
        mdl_lo = e.lo;
        sb.push_back(e);
    endtask

    always @(negedge clck) begin
        exp_t e;
        check_eq("dz_without_done", 64'(div_zero & ~done), 64'd0);
        if (done) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("hi", 64'(hi), 64'(e.hi));
                check_eq("lo", 64'(lo), 64'(e.lo));
                check_eq("div_zero", 64'(div_zero), 64'(e.dz));
            end
        end
    end

    // One operation; poke>0 pulses start (with junk operands) k cycles after the start edge
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input int poke);
        int k;
        int busy_cnt;
        int exp_lat;
        bit seen;
        exp_lat = (o == MDU_DIV && y == '0) ? 2 : int'(W) + 3;
        push_exp(o, x, y);
        @(negedge clck);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clck);
        #1;
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        k = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            @(posedge clck);
            #1;
            k++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            if (k == poke) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        check_eq("latency", 64'(k), 64'(exp_lat));
        check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
        repeat (2) begin
            @(posedge clck);
            #1;
            check_eq("idle_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic back_to_back(input logic [W-1:0] x, input logic [W-1:0] y);
        int d1;
        int d2;
        push_exp(MDU_MULT, x, y);
        push_exp(MDU_MULT, x, y);
        @(negedge clck);
        start = 1'b1; op = MDU_MULT; a = x; b = y;
        @(posedge clck);
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clck);
            #1;
            if (k == 36) start = 1'b0;
            if (done) begin
                if (d1 == 0) d1 = k;
                else d2 = k;
            end
            if (d2 != 0) break;
        end
        start = 1'b0;
        check_eq("b2b_first_done", 64'(d1), 64'(W + 3));
        check_eq("b2b_second_done", 64'(d2), 64'(2 * W + 7));
        repeat (3) begin
            @(posedge clck);
            #1;
            check_eq("b2b_idle_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic reset_abort();
        @(negedge clck);
        start = 1'b1; op = MDU_MULT; a = 32'h0000_1234; b = 32'h0000_5678;
        @(posedge clck);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clck);
        #1;
        reset = 1'b1;
        @(posedge clck);
        #1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_hi", 64'(hi), 64'd0);
        check_eq("abort_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        repeat (40) @(posedge clck);
        #1;
        check_eq("abort_quiet_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = MDU_MULT; a = '0; b = '0;
        repeat (3) @(posedge clck);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_div_zero", 64'(div_zero), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        run_op(MDU_MULT, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(MDU_DIV, 32'd100, 32'd7, 0);
        run_op(MDU_DIV, 32'd5, 32'd0, 0);
        run_op(MDU_MULT, 32'd123456, 32'hFFFF_FCEB, 10);
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        back_to_back(32'h0001_2345, 32'hFFF0_0001);
        reset_abort();
        run_op(MDU_MULT, 32'h0000_1234, 32'h0000_5678, 0);
        run_op(MDU_DIV, 32'hFFFF_FC18, 32'hFFFF_FFDF, 0);
        run_op(MDU_DIV, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        for (int i = 0; i < 8; i++) begin
            run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 0);
        end

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Iterative signed multiply/divide unit with its own controller, owning the HI/LO registers.
- The main control FSM issues `start` with `op` and waits for `done`. It then writes HI/LO to the register file through the existing mfhi/mflo paths.
- Replaces single-cycle mult/div. Flags divide-by-zero so the control FSM can branch to its exception states.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clck  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  1  0 = signed mult, 1 = signed div
a  in  WIDTH  multiplicand / dividend (rs)
b  in  WIDTH  multiplier / divisor (rt)
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse: operation finished, HI/LO updated or div_zero flagged
div_zero  out  1  one-cycle pulse coincident with done when a div had b == 0
hi  out  WIDTH  mult: upper product word; div: remainder
lo  out  WIDTH  mult: lower product word; div: quotient

Behaviour:
- Reset values: state IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
- A reset while busy aborts the operation the same edge. No done pulse; HI/LO are cleared.
- States and transitions:
  - IDLE: if start=1 at edge N, latch |a|, |b|, sign_a, sign_b and op; clear counter and working accumulators. Go to CHECK.
  - CHECK (edge N+1): if op=div and |b|==0, go to DONE with div_zero pending and HI/LO untouched. Otherwise go to RUN.
  - RUN: one iteration per cycle; counter increments; leave after exactly WIDTH iterations (counter == WIDTH-1). Go to FIX.
    - mult: unsigned shift-add over the magnitudes into a 2*WIDTH accumulator.
    - div: restoring division producing a WIDTH-bit quotient and remainder from the magnitudes.
  - FIX (one cycle): apply sign correction, write hi/lo, go to DONE.
    - mult: negate the 2*WIDTH product if sign_a^sign_b.
    - div: quotient negated if sign_a^sign_b; remainder takes the sign of the dividend (sign_a).
  - DONE: done=1 (and div_zero=1 if pending) for exactly this cycle, then IDLE.
- Timing:
  - busy=1 in CHECK, RUN and FIX; busy=0 in IDLE and DONE.
  - Normal latency: start sampled at edge N; done high during the cycle after edge N+WIDTH+3 (N+35 for WIDTH=32).
  - div-by-zero latency: done/div_zero high after edge N+2.
- Arithmetic/width rules:
  - Magnitude of -2^(WIDTH-1) is represented as the unsigned value 2^(WIDTH-1). No overflow internally.
  - div -2^31 / -1: quotient wraps, giving lo=0x80000000, hi=0. No flag.
  - mult never overflows: the full 64-bit result is kept.
- Handshake:
  - start is ignored outside IDLE, including in DONE; it is never queued.
  - a, b and op are captured at the start edge and may change afterwards.
  - start held high continuously launches a new operation on each IDLE visit.
- hi and lo change only in FIX (or on reset). They hold their value across div_zero and across subsequent idle cycles.

Decomposition:
- Package mdu_pkg contains:
  - op encodings: MDU_MULT=1'b0, MDU_DIV=1'b1
  - state enum: IDLE, CHECK, RUN, FIX, DONE
  - default WIDTH constant
- One natural sub-module, mdu_sign_fix: combinational conditional two's-complement negation of the quotient/remainder or the 2*WIDTH product, used in FIX.
- The controller and iteration datapath stay in mult_div_sequencer.

Test Plan:
- mult a=7, b=-3 (0xFFFFFFFD) → after 35 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0; busy high for exactly 34 cycles.
- mult a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- div a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then div a=100, b=7 → lo=14, hi=2.
- div by zero: preload hi=2/lo=14 via the prior op; div a=5, b=0 → done and div_zero both high in cycle N+2, hi/lo unchanged at 2/14; div_zero low on every other cycle.
- Pulse start during RUN with different a/b → ignored; result matches the first operation. Start held high → back-to-back ops separated by one IDLE cycle.
- Assert reset at iteration 10 of a mult → next edge busy=0, hi=lo=0, no done pulse; a fresh start afterwards completes normally.
